// File: rtl/barreira_pkg.sv
// Shared types and constants for the entry-gate barrier controller.
package barreira_pkg;

  typedef enum logic [1:0] {
    FECHADA,
    A_ABRIR,
    ABERTA,
    A_FECHAR
  } estado_t;

  localparam int          PLATE_W          = 24;
  localparam logic        BARREIRA_ABERTA  = 1'b0;
  localparam logic        BARREIRA_FECHADA = 1'b1;
  localparam logic [7:0]  REJ_MAX          = 8'hFF;

  typedef struct packed {
    logic               valida;
    logic [PLATE_W-1:0] placa;
  } pedido_t;

  // Timer width for the largest count; never below one bit.
  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// Two-flop synchronizer followed by a rising-edge detector.
module sincronizador_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulso_out
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized sample
  logic [2:0] sinc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sinc <= '0;
    else        sinc <= {sinc[1:0], async_in};
  end

  assign pulso_out = sinc[1] & ~sinc[2];

endmodule

// File: rtl/controlo_barreira.sv
// Entry-gate controller: admits plates, rejects immediate repeats, cycles the barrier.
module controlo_barreira
  import barreira_pkg::*;
#(
  parameter int T_MOTOR  = 4,
  parameter int T_ESPERA = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PLATE_W-1:0] matricula_in,
  input  logic               matricula_valida,
  input  logic               sensor_passagem,
  output logic [PLATE_W-1:0] Matriculas,
  output logic               barreira,
  output logic               evento,
  output logic               ocupado,
  output logic [7:0]         rejeitadas
);

  localparam int TW = timer_w(T_MOTOR, T_ESPERA);
  localparam logic [TW-1:0] T_MOTOR_INI  = TW'(T_MOTOR - 1);
  localparam logic [TW-1:0] T_ESPERA_INI = TW'(T_ESPERA - 1);

  estado_t            estado, nxt;
  logic [TW-1:0]      timer, timer_nxt;
  logic [PLATE_W-1:0] ultima;
  logic               ultima_valida;
  logic               passagem_ev;
  logic               aceita, rejeita, passou;
  pedido_t            pedido;

  assign pedido = '{valida: matricula_valida, placa: matricula_in};

  sincronizador_flanco u_sinc (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sensor_passagem),
    .pulso_out(passagem_ev)
  );

  always_comb begin
    nxt       = estado;
    timer_nxt = timer;
    aceita    = 1'b0;
    rejeita   = 1'b0;
    passou    = 1'b0;
    unique case (estado)
      FECHADA: begin
        if (pedido.valida) begin
          if (ultima_valida && pedido.placa == ultima) begin
            rejeita = 1'b1;
          end else begin
            aceita    = 1'b1;
            timer_nxt = T_MOTOR_INI;
            nxt       = A_ABRIR;
          end
        end
      end
      A_ABRIR: begin
        if (timer == '0) begin
          timer_nxt = T_ESPERA_INI;
          nxt       = ABERTA;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      ABERTA: begin
        // a passage on the last waiting cycle still counts as a passage
        if (passagem_ev) begin
          passou    = 1'b1;
          timer_nxt = T_MOTOR_INI;
          nxt       = A_FECHAR;
        end else if (timer == '0) begin
          timer_nxt = T_MOTOR_INI;
          nxt       = A_FECHAR;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      A_FECHAR: begin
        if (timer == '0) nxt = FECHADA;
        else             timer_nxt = timer - 1'b1;
      end
      default: nxt = FECHADA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= FECHADA;
      timer         <= '0;
      ultima        <= '0;
      ultima_valida <= 1'b0;
      Matriculas    <= '0;
      barreira      <= BARREIRA_FECHADA;
      evento        <= 1'b0;
      ocupado       <= 1'b0;
      rejeitadas    <= '0;
    end else begin
      estado  <= nxt;
      timer   <= timer_nxt;
      evento  <= passou;
      ocupado <= (nxt != FECHADA);
      // barrier output trails the state by one edge, so the plate settles first
      barreira <= (estado == ABERTA) ? BARREIRA_ABERTA : BARREIRA_FECHADA;
      if (aceita) Matriculas <= pedido.placa;
      if (passou) begin
        ultima        <= Matriculas;
        ultima_valida <= 1'b1;
      end
      if (rejeita && rejeitadas != REJ_MAX) rejeitadas <= rejeitadas + 8'd1;
    end
  end

endmodule

// File: tb/tb_controlo_barreira.sv
// Directed vector bench for controlo_barreira (T_MOTOR=4, T_ESPERA=50).
module tb_controlo_barreira;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] matricula_in;
  logic        matricula_valida;
  logic        sensor_passagem;
  logic [23:0] Matriculas;
  logic        barreira, evento, ocupado;
  logic [7:0]  rejeitadas;

  int total = 0;
  int passed = 0;

  controlo_barreira #(.T_MOTOR(4), .T_ESPERA(50)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .matricula_in    (matricula_in),
    .matricula_valida(matricula_valida),
    .sensor_passagem (sensor_passagem),
    .Matriculas      (Matriculas),
    .barreira        (barreira),
    .evento          (evento),
    .ocupado         (ocupado),
    .rejeitadas      (rejeitadas)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [23:0] placa;
    logic        sens;
    int          n;
    logic        bar;
    logic [23:0] mat;
    logic        ev;
    logic        ocu;
    logic [7:0]  rej;
  } vec_t;

  vec_t tab[30];

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    else passed++;
  endtask

  task automatic chk_all(input string p, input logic bar, input logic [23:0] mat,
                         input logic ev, input logic ocu, input logic [7:0] rej);
    chk({p, ".barreira"},   {31'd0, barreira}, {31'd0, bar});
    chk({p, ".Matriculas"}, {8'd0, Matriculas}, {8'd0, mat});
    chk({p, ".evento"},     {31'd0, evento},   {31'd0, ev});
    chk({p, ".ocupado"},    {31'd0, ocupado},  {31'd0, ocu});
    chk({p, ".rejeitadas"}, {24'd0, rejeitadas}, {24'd0, rej});
  endtask

  initial begin
    //             mv    placa        sens n   bar  mat          ev   ocu  rej
    tab[0]  = '{1'b0, 24'h0,      1'b0, 1,  1'b1, 24'h0,      1'b0, 1'b0, 8'd0};
    tab[1]  = '{1'b1, 24'hABC123, 1'b0, 1,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd0};
    tab[2]  = '{1'b0, 24'h0,      1'b0, 4,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd0};
    tab[3]  = '{1'b0, 24'h0,      1'b0, 1,  1'b0, 24'hABC123, 1'b0, 1'b1, 8'd0};
    tab[4]  = '{1'b0, 24'h0,      1'b1, 2,  1'b0, 24'hABC123, 1'b0, 1'b1, 8'd0};
    tab[5]  = '{1'b0, 24'h0,      1'b1, 1,  1'b0, 24'hABC123, 1'b1, 1'b1, 8'd0};
    tab[6]  = '{1'b0, 24'h0,      1'b1, 1,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd0};
    tab[7]  = '{1'b0, 24'h0,      1'b1, 2,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd0};
    tab[8]  = '{1'b0, 24'h0,      1'b1, 1,  1'b1, 24'hABC123, 1'b0, 1'b0, 8'd0};
    tab[9]  = '{1'b1, 24'hABC123, 1'b0, 1,  1'b1, 24'hABC123, 1'b0, 1'b0, 8'd1};
    tab[10] = '{1'b0, 24'h0,      1'b0, 3,  1'b1, 24'hABC123, 1'b0, 1'b0, 8'd1};
    tab[11] = '{1'b1, 24'h00FF01, 1'b0, 1,  1'b1, 24'h00FF01, 1'b0, 1'b1, 8'd1};
    tab[12] = '{1'b0, 24'h0,      1'b0, 5,  1'b0, 24'h00FF01, 1'b0, 1'b1, 8'd1};
    tab[13] = '{1'b0, 24'h0,      1'b1, 3,  1'b0, 24'h00FF01, 1'b1, 1'b1, 8'd1};
    tab[14] = '{1'b0, 24'h0,      1'b0, 1,  1'b1, 24'h00FF01, 1'b0, 1'b1, 8'd1};
    tab[15] = '{1'b0, 24'h0,      1'b0, 3,  1'b1, 24'h00FF01, 1'b0, 1'b0, 8'd1};
    // timeout: ABC123 admitted but never passes
    tab[16] = '{1'b1, 24'hABC123, 1'b0, 1,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[17] = '{1'b0, 24'h0,      1'b0, 5,  1'b0, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[18] = '{1'b0, 24'h0,      1'b0, 49, 1'b0, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[19] = '{1'b0, 24'h0,      1'b0, 1,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[20] = '{1'b0, 24'h0,      1'b0, 3,  1'b1, 24'hABC123, 1'b0, 1'b0, 8'd1};
    // same plate again is admitted; strobes while busy are ignored
    tab[21] = '{1'b1, 24'hABC123, 1'b0, 1,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[22] = '{1'b1, 24'h111111, 1'b0, 1,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[23] = '{1'b0, 24'h0,      1'b0, 4,  1'b0, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[24] = '{1'b1, 24'h222222, 1'b0, 1,  1'b0, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[25] = '{1'b0, 24'h0,      1'b0, 45, 1'b0, 24'hABC123, 1'b0, 1'b1, 8'd1};
    // passage lands on the final waiting cycle
    tab[26] = '{1'b0, 24'h0,      1'b1, 3,  1'b0, 24'hABC123, 1'b1, 1'b1, 8'd1};
    tab[27] = '{1'b0, 24'h0,      1'b0, 1,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[28] = '{1'b1, 24'h333333, 1'b0, 1,  1'b1, 24'hABC123, 1'b0, 1'b1, 8'd1};
    tab[29] = '{1'b0, 24'h0,      1'b0, 2,  1'b1, 24'hABC123, 1'b0, 1'b0, 8'd1};

    rst_n = 1'b0;
    matricula_in = '0;
    matricula_valida = 1'b0;
    sensor_passagem = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[i]) begin
      matricula_valida = tab[i].mv;
      matricula_in     = tab[i].placa;
      sensor_passagem  = tab[i].sens;
      @(negedge clk);
      matricula_valida = 1'b0;
      repeat (tab[i].n - 1) @(negedge clk);
      chk_all($sformatf("v%0d", i), tab[i].bar, tab[i].mat, tab[i].ev, tab[i].ocu, tab[i].rej);
    end

    // ABC123 has now passed: repeated reads saturate the reject counter
    matricula_in = 24'hABC123;
    for (int k = 0; k < 256; k++) begin
      matricula_valida = 1'b1;
      @(negedge clk);
      if (k == 0) chk("sat.first", {24'd0, rejeitadas}, 32'd2);
    end
    matricula_valida = 1'b0;
    @(negedge clk);
    chk_all("sat", 1'b1, 24'hABC123, 1'b0, 1'b0, 8'd255);

    // asynchronous reset while open
    matricula_in = 24'h444444;
    matricula_valida = 1'b1;
    @(negedge clk);
    matricula_valida = 1'b0;
    repeat (5) @(negedge clk);
    chk_all("pre_rst", 1'b0, 24'h444444, 1'b0, 1'b1, 8'd255);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 1'b1, 24'h0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    matricula_in = 24'hABC123;
    matricula_valida = 1'b1;
    @(negedge clk);
    matricula_valida = 1'b0;
    chk_all("post_rst", 1'b1, 24'hABC123, 1'b0, 1'b1, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
